// File: rtl/and_resp_checker.sv
// Response checker for an AND unit: recomputes a&b, aligns it to the unit's latency,
// compares against y, counts vectors/errors and latches the first mismatch.
module and_resp_checker #(
    parameter int WIDTH     = 1,
    parameter int LAT       = 0,
    parameter int N_VECTORS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      vec_count,
    output logic [15:0]      err_count,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH-1:0] first_fail_got,
    output logic [WIDTH-1:0] first_fail_exp
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] N_LAST = 16'(N_VECTORS - 1);
    localparam logic [15:0] N_TOT  = 16'(N_VECTORS);

    state_t           r_state;
    state_t           w_next;
    logic             r_busy;
    logic             r_done;
    logic [15:0]      r_acc;
    logic [15:0]      r_vec;
    logic [15:0]      r_err;
    logic             r_seen;
    logic [15:0]      r_ff_idx;
    logic [WIDTH-1:0] r_ff_got;
    logic [WIDTH-1:0] r_ff_exp;

    logic             w_start_ok;
    logic             w_accept;
    logic [WIDTH-1:0] w_and;
    logic             w_tag_out;
    logic [WIDTH-1:0] w_exp_out;
    logic             w_cmp;
    logic             w_mis;

    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_accept   = (r_state == S_RUN) & valid & (r_acc < N_TOT);
    assign w_and      = a & b;

    // With zero latency the accept itself is the aligned tag.
    generate
        if (LAT == 0) begin : g_lat0
            assign w_tag_out = w_accept;
            assign w_exp_out = w_and;
        end else begin : g_dline
            logic [LAT-1:0]   r_tag;
            logic [WIDTH-1:0] r_exp [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag[0] <= w_accept;
                    for (int i = 1; i < LAT; i++) begin
                        r_tag[i] <= r_tag[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                r_exp[0] <= w_and;
                for (int i = 1; i < LAT; i++) begin
                    r_exp[i] <= r_exp[i-1];
                end
            end

            assign w_tag_out = r_tag[LAT-1];
            assign w_exp_out = r_exp[LAT-1];
        end
    endgenerate

    assign w_cmp = w_tag_out & ((r_state == S_RUN) | (r_state == S_DRAIN));
    assign w_mis = w_cmp & (y != w_exp_out);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_accept && (r_acc == N_LAST)) w_next = (LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_cmp && (r_vec == N_LAST)) w_next = S_DONE;
            S_DONE:  if (start) w_next = S_RUN;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_acc    <= '0;
            r_vec    <= '0;
            r_err    <= '0;
            r_seen   <= 1'b0;
            r_ff_idx <= '0;
            r_ff_got <= '0;
            r_ff_exp <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == S_RUN) | (w_next == S_DRAIN);
            r_done  <= (w_next == S_DONE);
            if (w_start_ok) begin
                r_acc    <= '0;
                r_vec    <= '0;
                r_err    <= '0;
                r_seen   <= 1'b0;
                r_ff_idx <= '0;
                r_ff_got <= '0;
                r_ff_exp <= '0;
            end else begin
                if (w_accept) r_acc <= r_acc + 16'd1;
                if (w_cmp) r_vec <= r_vec + 16'd1;
                if (w_mis) begin
                    if (r_err != 16'hFFFF) r_err <= r_err + 16'd1;
                    // Only the first mismatch of a run is recorded.
                    if (!r_seen) begin
                        r_seen   <= 1'b1;
                        r_ff_idx <= r_vec;
                        r_ff_got <= y;
                        r_ff_exp <= w_exp_out;
                    end
                end
            end
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign pass           = r_done & (r_err == 16'd0);
    assign vec_count      = r_vec;
    assign err_count      = r_err;
    assign first_fail_idx = r_ff_idx;
    assign first_fail_got = r_ff_got;
    assign first_fail_exp = r_ff_exp;

endmodule
